// File: rtl/adma_pkg.sv
// Shared AXI constants and the outstanding-transaction entry layout for the ADMA completion path.
package adma_pkg;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIX  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam int unsigned ADMA_MST_ID_W = 5;

    // One outstanding AXI transaction: last flags the final one of a DMA transaction.
    typedef struct packed {
        logic                     last;
        logic [ADMA_MST_ID_W-1:0] id;
    } atx_entry_t;

    // SLVERR and DECERR are failures; OKAY and EXOKAY are success.
    function automatic logic bresp_is_err(input logic [1:0] resp);
        return (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
    endfunction

endpackage

// File: rtl/adma_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only alongside a pop.
module adma_sync_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and count next state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/adma_as_atx_cmpl.sv
// Tracks issued AXI transactions, consumes B responses and reports DMA-transaction completion.
module adma_as_atx_cmpl
    import adma_pkg::*;
#(
    parameter int unsigned MST_ID_W    = 5,
    parameter int unsigned OUTST_NUM   = 8,
    parameter int unsigned OUTST_CNT_W = $clog2(OUTST_NUM + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   atx_start,
    input  logic                   atx_start_last,
    input  logic [MST_ID_W-1:0]    atx_id,
    output logic                   atx_full,
    input  logic [MST_ID_W-1:0]    bid,
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready,
    output logic                   tx_cmpl_vld,
    output logic                   tx_cmpl_err,
    input  logic                   tx_cmpl_rdy,
    output logic [OUTST_CNT_W-1:0] outst_cnt,
    output logic                   idle,
    output logic                   ovf_err
);

    logic [MST_ID_W:0]      head;
    logic                   head_last;
    logic [MST_ID_W-1:0]    head_id;
    logic                   fifo_empty;
    logic                   b_hs;
    logic                   cur_err;

    logic cmpl_vld_q, cmpl_vld_d;
    logic cmpl_err_q, cmpl_err_d;
    logic err_acc_q, err_acc_d;
    logic ovf_q, ovf_d;

    adma_sync_fifo #(
        .WIDTH (1 + MST_ID_W),
        .DEPTH (OUTST_NUM),
        .CNT_W (OUTST_CNT_W)
    ) u_outst_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (atx_start),
        .wdata_i ({atx_start_last, atx_id}),
        .pop_i   (b_hs),
        .rdata_o (head),
        .full_o  (atx_full),
        .empty_o (fifo_empty),
        .count_o (outst_cnt)
    );

    assign head_last = head[MST_ID_W];
    assign head_id   = head[MST_ID_W-1:0];

    // B is stalled while an unaccepted completion would otherwise be overwritten.
    assign bready  = ~fifo_empty & (~cmpl_vld_q | tx_cmpl_rdy);
    assign b_hs    = bvalid & bready;
    assign cur_err = bresp_is_err(bresp) | (bid != head_id);

    assign tx_cmpl_vld = cmpl_vld_q;
    assign tx_cmpl_err = cmpl_err_q;
    assign ovf_err     = ovf_q;
    // Decoded IDLE state: nothing outstanding and no completion pending.
    assign idle        = (outst_cnt == '0) & ~cmpl_vld_q;

    // Error accumulation, completion hand-off and overflow detection.
    always_comb begin
        cmpl_vld_d = cmpl_vld_q;
        cmpl_err_d = cmpl_err_q;
        err_acc_d  = err_acc_q;
        ovf_d      = ovf_q;
        if (cmpl_vld_q && tx_cmpl_rdy) cmpl_vld_d = 1'b0;
        if (b_hs) begin
            if (head_last) begin
                cmpl_vld_d = 1'b1;
                cmpl_err_d = err_acc_q | cur_err;
                err_acc_d  = 1'b0;
            end else begin
                err_acc_d  = err_acc_q | cur_err;
            end
        end
        // A pop in the same cycle frees a slot, so that push is not an overflow.
        if (atx_start && atx_full && !b_hs) ovf_d = 1'b1;
    end

    // Completion and error state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmpl_vld_q <= 1'b0;
            cmpl_err_q <= 1'b0;
            err_acc_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cmpl_vld_q <= cmpl_vld_d;
            cmpl_err_q <= cmpl_err_d;
            err_acc_q  <= err_acc_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_adma_as_atx_cmpl.sv
// Scoreboard bench: a queue-based model predicts completions; a monitor checks them on handshake.
module tb_adma_as_atx_cmpl;

    localparam int IdW = 5;
    localparam int Num = 8;
    localparam int CntW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            atx_start = 1'b0;
    logic            atx_start_last = 1'b0;
    logic [IdW-1:0]  atx_id = '0;
    logic            atx_full;
    logic [IdW-1:0]  bid = '0;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b0;
    logic            bready;
    logic            tx_cmpl_vld;
    logic            tx_cmpl_err;
    logic            tx_cmpl_rdy = 1'b0;
    logic [CntW-1:0] outst_cnt;
    logic            idle;
    logic            ovf_err;

    adma_as_atx_cmpl #(
        .MST_ID_W  (IdW),
        .OUTST_NUM (Num)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .atx_start      (atx_start),
        .atx_start_last (atx_start_last),
        .atx_id         (atx_id),
        .atx_full       (atx_full),
        .bid            (bid),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .tx_cmpl_vld    (tx_cmpl_vld),
        .tx_cmpl_err    (tx_cmpl_err),
        .tx_cmpl_rdy    (tx_cmpl_rdy),
        .outst_cnt      (outst_cnt),
        .idle           (idle),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           last;
        logic [IdW-1:0] id;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    bit   exp_q[$];
    bit   m_vld, m_err, m_acc, m_ovf;
    bit   after_rst;
    int   n_pass = 0;
    int   n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, compare against model, then advance the model.
    task automatic cycle(input bit r, input bit st, input bit lst, input logic [IdW-1:0] id,
                         input bit bv, input logic [IdW-1:0] bi, input logic [1:0] br,
                         input bit rd);
        bit   exp_bready, hs, ce, nxt_vld;
        ent_t h;
        @(negedge clk);
        rst = r; atx_start = st; atx_start_last = lst; atx_id = id;
        bvalid = bv; bid = bi; bresp = br; tx_cmpl_rdy = rd;
        #1;
        if (r) begin
            mq.delete(); exp_q.delete();
            m_vld = 0; m_err = 0; m_acc = 0; m_ovf = 0;
            after_rst = 1;
            return;
        end
        exp_bready = (mq.size() != 0) && (!m_vld || rd);
        check("bready", bready, exp_bready);
        check("outst_cnt", outst_cnt, mq.size());
        check("atx_full", atx_full, mq.size() == Num);
        check("idle", idle, mq.size() == 0 && !m_vld);
        check("ovf_err", ovf_err, m_ovf);
        check("tx_cmpl_vld", tx_cmpl_vld, m_vld);
        if (m_vld || after_rst) check("tx_cmpl_err", tx_cmpl_err, m_err);
        after_rst = 0;

        hs = bv && exp_bready;
        nxt_vld = m_vld && !rd;
        if (hs) begin
            h = mq.pop_front();
            ce = (br == 2'b10) || (br == 2'b11) || (bi != h.id);
            if (h.last) begin
                nxt_vld = 1;
                m_err = m_acc | ce;
                m_acc = 0;
                exp_q.push_back(m_err);
            end else begin
                m_acc = m_acc | ce;
            end
        end
        m_vld = nxt_vld;
        if (st) begin
            if (mq.size() < Num) mq.push_back(ent_t'{last: lst, id: id});
            else m_ovf = 1;
        end
    endtask

    function automatic logic [IdW-1:0] head_id();
        return (mq.size() != 0) ? mq[0].id : '0;
    endfunction

    task automatic rnd(input int pst, input int pbv, input int prd, input int perr);
        bit             st, lst, bv, rd;
        logic [IdW-1:0] id, bi;
        logic [1:0]     br;
        st  = ($urandom % 100) < pst;
        lst = ($urandom % 3) == 0;
        id  = IdW'($urandom);
        bv  = ($urandom % 100) < pbv;
        bi  = (($urandom % 10) != 0) ? head_id() : IdW'($urandom);
        br  = (($urandom % 100) < perr) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
        rd  = ($urandom % 100) < prd;
        cycle(0, st, lst, id, bv, bi, br, rd);
    endtask

    // Monitor: every accepted completion must match the oldest predicted one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && tx_cmpl_vld === 1'b1 && tx_cmpl_rdy === 1'b1) begin
                check("cmpl_predicted", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("cmpl_err_sb", tx_cmpl_err, exp_q.pop_front());
            end
        end
    end

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);  // reset state

        // 1: three transactions all OKAY
        for (int i = 0; i < 3; i++) cycle(0, 1, i == 2, 5, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 5, 2'b00, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // 2: SLVERR in middle, then a clean transaction clears the accumulator
        for (int i = 0; i < 3; i++) cycle(0, 1, i == 2, 5, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 5, (i == 1) ? 2'b10 : 2'b01, 1);
        for (int i = 0; i < 2; i++) cycle(0, 1, i == 1, 7, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 1, 7, 2'b00, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // 3: fill, overflow, push+pop at full
        for (int i = 0; i < Num; i++) cycle(0, 1, i == Num - 1, IdW'(i), 0, 0, 0, 1);
        cycle(0, 1, 1, 9, 0, 0, 0, 1);
        cycle(0, 1, 1, 10, 1, head_id(), 2'b00, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < Num; i++) cycle(0, 0, 0, 0, 1, head_id(), 2'b00, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // 4: pending completion back-pressures B
        for (int i = 0; i < 2; i++) cycle(0, 1, 1, 4, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 4, 2'b00, 0);
        repeat (3) cycle(0, 0, 0, 0, 1, 4, 2'b00, 0);
        cycle(0, 0, 0, 0, 1, 4, 2'b11, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // 5: bvalid on empty queue, then ID mismatch on last entry
        repeat (3) cycle(0, 0, 0, 0, 1, 5, 2'b00, 1);
        cycle(0, 1, 1, 5, 1, 5, 2'b00, 1);
        cycle(0, 0, 0, 0, 1, 3, 2'b00, 1);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // 6: reset with four outstanding
        for (int i = 0; i < 4; i++) cycle(0, 1, i == 3, 2, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 1, 2, 2'b00, 1);

        // Random phases: balanced, fill-heavy, drain-heavy, slow consumer
        repeat (400) rnd(50, 50, 70, 15);
        repeat (200) rnd(90, 20, 50, 10);
        repeat (200) rnd(20, 90, 90, 20);
        repeat (200) rnd(60, 80, 20, 30);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (400) rnd(60, 60, 60, 25);

        // Drain with a bounded cycle budget
        for (int k = 0; k < 200 && (mq.size() != 0 || m_vld); k++)
            cycle(0, 0, 0, 0, 1, head_id(), 2'b00, 1);
        check("drain_done", (mq.size() == 0) && !m_vld, 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
